// File: rtl/inp_addr_mapper.sv
// Maps a phoneme/word code to a burst of BURST_LEN template-table addresses starting at (code-1)*STRIDE.
// Define INP_MAP_CLAMP_EN to clamp codes above MAX_CODE instead of rejecting them.
module inp_addr_mapper #(
   parameter int IN_W      = 8,
   parameter int OUT_W     = 8,
   parameter int STRIDE    = 8,
   parameter int MAX_CODE  = 20,
   parameter int BURST_LEN = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_addr,
   output logic             out_last,
   output logic             busy,
   output logic             err
);

   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [31:0]       MAX_U     = 32'(MAX_CODE);
   localparam logic [31:0]       STRIDE_U  = 32'(STRIDE);

   typedef enum logic {IDLE, BURST} state_e;

   state_e            state_q, state_d;
   logic [OUT_W-1:0]  base_q, base_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              err_q, err_d;

   logic              code_ok;
   logic [31:0]       code_eff;

   always_comb begin
`ifdef INP_MAP_CLAMP_EN
      code_ok  = (in_code != '0);
      code_eff = (32'(in_code) > MAX_U) ? MAX_U : 32'(in_code);
`else
      code_ok  = (in_code != '0) && (32'(in_code) <= MAX_U);
      code_eff = 32'(in_code);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      beat_d    = beat_q;
      err_d     = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_last  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (code_ok) begin
                  base_d  = OUT_W'((code_eff - 32'd1) * STRIDE_U);
                  beat_d  = '0;
                  state_d = BURST;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         BURST: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_last  = (beat_q == LAST_BEAT);
            // Last handshake drops straight to IDLE; the input side opens one cycle later.
            if (out_ready) begin
               if (out_last) state_d = IDLE;
               else          beat_d  = beat_q + BEAT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_addr = base_q + OUT_W'(beat_q);
   assign err      = err_q;

endmodule

// File: tb/tb_inp_addr_mapper.sv
// Randomized and directed bench for inp_addr_mapper against a per-code address-list model.
module tb_inp_addr_mapper;
   localparam int IN_W = 8, OUT_W = 8, STRIDE = 8, MAX_CODE = 20, BURST_LEN = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready, out_valid, out_ready, out_last, busy, err;
   logic [IN_W-1:0]  in_code;
   logic [OUT_W-1:0] out_addr;

   int checks = 0;
   int errors = 0;

   inp_addr_mapper #(.IN_W(IN_W), .OUT_W(OUT_W), .STRIDE(STRIDE), .MAX_CODE(MAX_CODE),
                     .BURST_LEN(BURST_LEN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_last(out_last),
      .busy(busy), .err(err));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: a code is either rejected, or expands into the list of its addresses.
   task automatic model(input int code, output bit ok, output int q[$]);
      int c;
      c  = code;
      q  = {};
`ifdef INP_MAP_CLAMP_EN
      if (c > MAX_CODE) c = MAX_CODE;
      ok = (c != 0);
`else
      ok = (c != 0) && (c <= MAX_CODE);
`endif
      if (ok)
         for (int b = 0; b < BURST_LEN; b++) q.push_back(((c - 1) * STRIDE + b) % (1 << OUT_W));
   endtask

   // mode 0: out_ready always 1; 1: random backpressure; 2: 3-cycle stall at beat 2
   task automatic run_code(input int code, input int mode);
      bit ok;
      int q[$];
      int cyc, beat, stall;
      logic [31:0] cv;
      model(code, ok, q);
      cv        = code;
      in_valid  = 1'b1;
      in_code   = cv[IN_W-1:0];
      out_ready = 1'b1;
      check("in_ready_before_accept", in_ready, 1);
      step();
      in_valid = 1'b0;
      if (!ok) begin
         check("rej_err", err, 1);
         check("rej_out_valid", out_valid, 0);
         check("rej_in_ready", in_ready, 1);
         check("rej_busy", busy, 0);
         step();
         check("rej_err_clear", err, 0);
         check("rej_out_valid2", out_valid, 0);
         return;
      end
      cyc = 0; beat = 0; stall = 0;
      while (q.size() > 0 && cyc < 200) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: begin
               out_ready = !(beat == 2 && stall < 3);
               if (!out_ready) stall++;
            end
         endcase
         in_valid = $urandom_range(0, 1) != 0;
         in_code  = IN_W'($urandom);
         check("b_out_valid", out_valid, 1);
         check("b_busy", busy, 1);
         check("b_in_ready", in_ready, 0);
         check("b_err", err, 0);
         check("b_out_addr", out_addr, q[0]);
         check("b_out_last", out_last, (q.size() == 1) ? 1 : 0);
         if (out_ready) begin
            void'(q.pop_front());
            beat++;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      check("burst_remaining", q.size(), 0);
      check("end_in_ready", in_ready, 1);
      check("end_out_valid", out_valid, 0);
      check("end_busy", busy, 0);
      check("end_err", err, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_out_addr", out_addr, 0);
      check("rst_out_last", out_last, 0);
      check("rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      step();

      run_code(3, 0);
      run_code(1, 0);
      run_code(20, 0);
      run_code(0, 0);
      run_code(25, 0);
      run_code(3, 2);

      // Reset in the middle of a burst
      in_valid = 1'b1; in_code = 8'd3; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      check("mid_addr_beat4", out_addr, 20);
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_out_addr", out_addr, 0);
      check("mid_rst_out_last", out_last, 0);
      check("mid_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1);
      step();
      check("post_rst_in_ready2", in_ready, 1);
      check("post_rst_out_valid", out_valid, 0);

      for (int i = 0; i < 40; i++) run_code($urandom_range(0, 30), $urandom_range(0, 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
